// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with per-register busy scoreboard
// Post-reset CLEAR pass zeroes the file; reads are registered with write bypass.
module regfile_sb #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6,
    parameter int NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    ready,
    input  logic [NREAD*ADDR_W-1:0] r_rn,
    output logic [NREAD*DATA_W-1:0] r_data,
    output logic [NREAD-1:0]        r_busy,
    input  logic                    w_en,
    input  logic [ADDR_W-1:0]       w_rn,
    input  logic [DATA_W-1:0]       w_data,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_rn,
    input  logic                    flush
);

    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_RN = ADDR_W'(DEPTH-1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_ready;

    logic [DATA_W-1:0] r_file [1:DEPTH-1];
    logic [DEPTH-1:1]  r_busy_vec;
    logic [DEPTH-1:1]  w_busy_nxt;

    logic              w_run;
    logic              w_wr_hit;
    logic              w_rsv_hit;

    assign w_run     = (r_state == ST_RUN);
    assign w_wr_hit  = w_run && w_en && (w_rn != '0);
    assign w_rsv_hit = w_run && rsv_en && (rsv_rn != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + ADDR_W'(1);
                if (r_cnt == LAST_RN) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= ADDR_W'(1);
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == ST_RUN);
        end
    end

    // File contents carry no reset; the CLEAR sweep is what zeroes them.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_file[r_cnt] <= '0;
        end else if (w_wr_hit) begin
            r_file[w_rn] <= w_data;
        end
    end

    // Reserve is applied after the write clear so it wins; flush overrides all.
    always_comb begin
        w_busy_nxt = r_busy_vec;
        if (w_wr_hit) begin
            w_busy_nxt[w_rn] = 1'b0;
        end
        if (w_rsv_hit) begin
            w_busy_nxt[rsv_rn] = 1'b1;
        end
        if (w_run && flush) begin
            w_busy_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_vec <= '0;
        end else begin
            r_busy_vec <= w_busy_nxt;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_rd_rn;
        logic [DATA_W-1:0] w_rd_data;
        logic              w_rd_busy;
        logic [DATA_W-1:0] r_rd_data;
        logic              r_rd_busy;

        assign w_rd_rn = r_rn[g*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd_data = '0;
            w_rd_busy = 1'b0;
            if (w_run && (w_rd_rn != '0)) begin
                w_rd_data = (w_wr_hit && (w_rn == w_rd_rn)) ? w_data : r_file[w_rd_rn];
                w_rd_busy = w_busy_nxt[w_rd_rn];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_data <= '0;
                r_rd_busy <= 1'b0;
            end else begin
                r_rd_data <= w_rd_data;
                r_rd_busy <= w_rd_busy;
            end
        end

        assign r_data[g*DATA_W +: DATA_W] = r_rd_data;
        assign r_busy[g]                  = r_rd_busy;
    end

    assign ready = r_ready;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register data width.
REQ-002 SHALL have parameter ADDR_W, default 6, register-number width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NREAD, default 2, number of read ports (>=1).
REQ-004 SHALL have port clk  in  1  single clock; all flops rising-edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port ready  out  1  high once post-reset clear is complete.
REQ-007 SHALL have port r_rn  in  NREAD*ADDR_W  read register numbers, port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port r_data  out  NREAD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W].
REQ-009 SHALL have port r_busy  out  NREAD  registered per-port pending-write flag.
REQ-010 SHALL have port w_en  in  1  write enable.
REQ-011 SHALL have port w_rn  in  ADDR_W  write register number.
REQ-012 SHALL have port w_data  in  DATA_W  write data.
REQ-013 SHALL have port rsv_en  in  1  reserve: mark register rsv_rn busy.
REQ-014 SHALL have port rsv_rn  in  ADDR_W  register number to reserve.
REQ-015 SHALL have port flush  in  1  clear all busy bits.

Function
REQ-016 SHALL hold DEPTH-1 data registers (1..DEPTH-1) plus a DEPTH-1 bit busy vector; register 0 reads zero, never busy, writes/reservations to 0 ignored.
REQ-017 SHALL implement FSM states CLEAR and RUN; reset enters CLEAR with clear counter = 1.
REQ-018 SHALL in CLEAR write zero to file[counter] each cycle, increment counter, go to RUN the cycle after writing DEPTH-1 (DEPTH-1 cycles total).
REQ-019 SHALL drive ready = 1 only in RUN, registered.
REQ-020 SHALL in CLEAR ignore w_en, rsv_en, flush and drive r_data = 0, r_busy = 0.
REQ-021 SHALL in RUN write w_data to file[w_rn] at the clock edge when w_en and w_rn != 0, and clear busy[w_rn].
REQ-022 SHALL in RUN set busy[rsv_rn] when rsv_en and rsv_rn != 0.
REQ-023 SHALL on same-edge write and reserve to the same register store w_data and leave busy set (reserve wins).
REQ-024 SHALL on flush clear all busy bits; flush wins over same-cycle rsv_en; same-cycle write still updates data.
REQ-025 SHALL give read latency 1: r_data port i at edge n+1 reflects r_rn port i sampled at edge n.
REQ-026 SHALL bypass: if w_en and w_rn == r_rn[i] != 0 in the same cycle, r_data[i] <= w_data.
REQ-027 SHALL compute r_busy[i] <= next-state busy of r_rn[i] (after this cycle's write clear, reserve, flush), 0 for register 0.
REQ-028 SHALL let all read ports read the same or different registers independently with no conflicts.

Reset
REQ-029 SHALL on rst_n low, asynchronously: ready = 0, r_data = 0, r_busy = 0, all busy bits = 0, FSM = CLEAR, counter = 1.
REQ-030 SHALL treat reset asserted mid-CLEAR or mid-RUN identically; clear restarts from register 1 after release.
REQ-031 SHALL not reset file contents asynchronously; CLEAR zeroes them.

Verification
REQ-032 SHALL cover: release reset, defaults -> ready rises after exactly 63 cycles; any read during/after clear returns 0.
REQ-033 SHALL cover: write r5 = 0xDEAD_BEEF, read r5 on both ports next cycle -> both r_data = 0xDEADBEEF one cycle later, r_busy = 0.
REQ-034 SHALL cover: same-cycle w_en r7 = 0x1234 and r_rn[0] = 7 -> r_data[0] = 0x1234 next cycle (bypass).
REQ-035 SHALL cover: rsv r9, read r9 -> r_busy[0] = 1; write r9 = 0x55 -> same-cycle read gives 0x55, r_busy 0; rsv + write r9 same cycle -> r_busy 1.
REQ-036 SHALL cover: reserve r3, r4; flush with rsv r6 -> reads of r3, r4, r6 all r_busy = 0; write/read r0 = 0xFF -> r_data 0, r_busy 0.
REQ-037 SHALL cover: rst_n pulsed low mid-RUN with busy bits set -> outputs 0 immediately, ready low, 63-cycle clear reruns, old values read as 0.
